// File: rtl/mic_translator.sv
// I2S master/receiver for a 24-bit MEMS microphone: generates BCLK/LRCLK,
// captures left-channel samples and publishes blocks of 16 10-bit samples.
module mic_translator #(
  parameter int CLK_DIV   = 16,
  parameter bit SYNC_DOUT = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DOUT,
  output logic       LRCLK,
  output logic       BCLK,
  output logic       new_t,
  output logic [9:0] t0,
  output logic [9:0] t1,
  output logic [9:0] t2,
  output logic [9:0] t3,
  output logic [9:0] t4,
  output logic [9:0] t5,
  output logic [9:0] t6,
  output logic [9:0] t7,
  output logic [9:0] t8,
  output logic [9:0] t9,
  output logic [9:0] t10,
  output logic [9:0] t11,
  output logic [9:0] t12,
  output logic [9:0] t13,
  output logic [9:0] t14,
  output logic [9:0] t15
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt_reg;
  logic        bclk_reg;
  logic [5:0]  bit_cnt_reg;
  logic [23:0] shift_reg;
  logic [3:0]  widx_reg;
  logic        publish_reg;
  logic        new_t_reg;
  logic        dout_s;

  logic        tick;
  logic        bclk_rise;
  logic        bclk_fall;
  logic        capture;
  logic        last_bit;
  logic [23:0] sample_full;

  logic [9:0]  buf_q [16];
  logic [9:0]  t_q   [16];

  // Optional DOUT synchroniser; two CLK of latency stays inside the BCLK
  // half-period only when CLK_DIV >= 4.
  generate
    if (SYNC_DOUT) begin : g_sync
      logic [1:0] sync_reg;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync_reg <= 2'b00;
        end else begin
          sync_reg <= {sync_reg[0], DOUT};
        end
      end
      assign dout_s = sync_reg[1];
    end else begin : g_nosync
      assign dout_s = DOUT;
    end
  endgenerate

  assign tick        = (div_cnt_reg == DIV_LAST);
  assign bclk_rise   = tick & ~bclk_reg;
  assign bclk_fall   = tick & bclk_reg;
  assign capture     = bclk_rise && (bit_cnt_reg >= 6'd1) && (bit_cnt_reg <= 6'd24);
  assign last_bit    = bclk_rise && (bit_cnt_reg == 6'd24);
  assign sample_full = {shift_reg[22:0], dout_s};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_reg <= 8'd0;
      bclk_reg    <= 1'b0;
      bit_cnt_reg <= 6'd0;
    end else begin
      if (tick) begin
        div_cnt_reg <= 8'd0;
        bclk_reg    <= ~bclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + 8'd1;
      end
      if (bclk_fall) begin
        bit_cnt_reg <= bit_cnt_reg + 6'd1;
      end
    end
  end

  // Left-slot bits 1..24 are the 24-bit sample, MSB first (one-bit I2S delay).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_reg   <= 24'd0;
      widx_reg    <= 4'd0;
      publish_reg <= 1'b0;
      new_t_reg   <= 1'b0;
    end else begin
      if (capture) begin
        shift_reg <= sample_full;
      end
      if (last_bit) begin
        widx_reg <= widx_reg + 4'd1;
      end
      publish_reg <= last_bit && (widx_reg == 4'd15);
      new_t_reg   <= publish_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      logic [9:0] entry_reg;
      logic [9:0] t_entry_reg;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          entry_reg   <= 10'd0;
          t_entry_reg <= 10'd0;
        end else begin
          if (last_bit && (widx_reg == 4'(gi))) begin
            entry_reg <= sample_full[23:14];
          end
          if (publish_reg) begin
            t_entry_reg <= entry_reg;
          end
        end
      end

      assign buf_q[gi] = entry_reg;
      assign t_q[gi]   = t_entry_reg;
    end
  endgenerate

  assign BCLK  = bclk_reg;
  assign LRCLK = bit_cnt_reg[5];
  assign new_t = new_t_reg;

  assign t0  = t_q[0];
  assign t1  = t_q[1];
  assign t2  = t_q[2];
  assign t3  = t_q[3];
  assign t4  = t_q[4];
  assign t5  = t_q[5];
  assign t6  = t_q[6];
  assign t7  = t_q[7];
  assign t8  = t_q[8];
  assign t9  = t_q[9];
  assign t10 = t_q[10];
  assign t11 = t_q[11];
  assign t12 = t_q[12];
  assign t13 = t_q[13];
  assign t14 = t_q[14];
  assign t15 = t_q[15];

endmodule

// File: tb/tb_mic_translator.sv
// Directed bench for mic_translator: a behavioural I2S microphone drives DOUT
// and published blocks are compared against hand-computed values.
module tb_mic_translator;

  localparam int D = 4;
  localparam int FIRST_PULSE = 1969 * D + 1;
  localparam int PERIOD      = 2048 * D;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DOUT;
  logic       LRCLK;
  logic       BCLK;
  logic       new_t;
  logic [9:0] tv [16];

  int cyc = 0;
  int rel = 0;
  int errors = 0;
  int checks = 0;
  int mode = 0;
  logic [5:0] pos;
  int frame;

  mic_translator #(.CLK_DIV(D), .SYNC_DOUT(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .DOUT(DOUT), .LRCLK(LRCLK), .BCLK(BCLK), .new_t(new_t),
    .t0(tv[0]), .t1(tv[1]), .t2(tv[2]), .t3(tv[3]), .t4(tv[4]), .t5(tv[5]),
    .t6(tv[6]), .t7(tv[7]), .t8(tv[8]), .t9(tv[9]), .t10(tv[10]), .t11(tv[11]),
    .t12(tv[12]), .t13(tv[13]), .t14(tv[14]), .t15(tv[15])
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Microphone model: mode 0 all ones, 1 = 800000, 2 = 7FC000, 3 = ones only
  // in right slot, 4 = ramp k, 5 = ramp 100+k. Unused slots carry noise.
  function automatic logic mic_bit(input int m, input logic [5:0] p, input int f);
    logic [23:0] s;
    int k;
    case (m)
      0: return 1'b1;
      3: return p[5];
      default: begin
        if (m == 1)      s = 24'h800000;
        else if (m == 2) s = 24'h7FC000;
        else if (m == 4) s = {10'(f % 16), 14'h0};
        else             s = {10'(100 + f % 16), 14'h0};
        if (!p[5] && p >= 6'd1 && p <= 6'd24) begin
          k = 24 - int'(p);
          return s[k];
        end
        return 1'($urandom_range(1, 0));
      end
    endcase
  endfunction

  always @(negedge BCLK or negedge RST_N) begin
    if (!RST_N) begin
      pos   = 6'd0;
      frame = 0;
      DOUT  = 1'b0;
    end else begin
      pos = pos + 6'd1;
      if (pos == 6'd0) frame++;
      DOUT = mic_bit(mode, pos, frame);
    end
  end

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    rel = cyc;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    release_reset();
  endtask

  task automatic wait_pulse(output int at);
    at = -1;
    for (int i = 0; i < 2200 * D; i++) begin
      @(negedge CLK);
      if (new_t === 1'b1) begin
        at = cyc - rel;
        break;
      end
    end
    if (at < 0) check("pulse_timeout", 0, 1);
  endtask

  task automatic check_block(input string tag, input int base, input int step);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_t%0d", tag, i), 32'(tv[i]), 32'((base + step * i) & 10'h3FF));
  endtask

  initial begin
    int at;
    int at2;
    int n;

    // Reset state
    mode = 0;
    repeat (4) @(negedge CLK);
    check("rst_bclk", BCLK, 0);
    check("rst_lrclk", LRCLK, 0);
    check("rst_new_t", new_t, 0);
    check_block("rst", 0, 0);
    release_reset();

    // Clock generation
    repeat (D - 1) @(negedge CLK);
    check("bclk_before_rise", BCLK, 0);
    @(negedge CLK);
    check("bclk_rise", BCLK, 1);
    repeat (D) @(negedge CLK);
    check("bclk_fall", BCLK, 0);
    repeat (64 * D - 1 - 2 * D) @(negedge CLK);
    check("lrclk_before", LRCLK, 0);
    @(negedge CLK);
    check("lrclk_toggle", LRCLK, 1);

    // DOUT held high
    wait_pulse(at);
    check("first_pulse_cyc", at, FIRST_PULSE);
    check_block("ones", 10'h3FF, 0);
    @(negedge CLK);
    check("pulse_width", new_t, 0);
    wait_pulse(at2);
    check("pulse_period", at2 - at, PERIOD);
    $display("block ones: first=%0d period=%0d", at, at2 - at);

    // Most negative sample
    mode = 1;
    apply_reset();
    wait_pulse(at);
    check_block("neg_full", 10'h200, 0);
    $display("block 800000: t0=%0h t15=%0h", tv[0], tv[15]);

    // Just below full scale, truncated
    mode = 2;
    apply_reset();
    wait_pulse(at);
    check_block("pos_trunc", 10'h1FF, 0);
    $display("block 7FC000: t0=%0h t15=%0h", tv[0], tv[15]);

    // Right slot only
    mode = 3;
    apply_reset();
    wait_pulse(at);
    check("right_pulse_seen", at, FIRST_PULSE);
    check_block("right_only", 0, 0);
    $display("block right-only: t0=%0h t15=%0h", tv[0], tv[15]);

    // Ramp
    mode = 4;
    apply_reset();
    wait_pulse(at);
    check_block("ramp", 0, 1);
    $display("block ramp: t0=%0h t15=%0h", tv[0], tv[15]);

    // Reset mid-block after 7 captured samples of the next block
    n = 0;
    while (!(frame == 23 && pos == 6'd10) && n < 4000 * D) begin
      @(negedge CLK);
      n++;
    end
    check("mid_block_reached", frame, 23);
    mode = 5;
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_new_t", new_t, 0);
    check("midrst_bclk", BCLK, 0);
    check_block("midrst", 0, 0);
    repeat (2) @(negedge CLK);
    release_reset();
    wait_pulse(at);
    check("post_rst_pulse_cyc", at, FIRST_PULSE);
    check_block("fresh", 100, 1);
    $display("block after reset: at=%0d t0=%0h t15=%0h", at, tv[0], tv[15]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
